// File: rtl/module_acc_drain_pkg.sv
// Shared widths, leaky-ReLU constants, FSM states and the per-element
// requantisation math used by the accumulation-buffer drain.
package module_acc_drain_pkg;

  localparam int ACC_W     = 18;
  localparam int SUM_W     = ACC_W + 1;
  localparam int OUT_W     = 8;
  localparam int LEAKY_MUL = 13;
  localparam int LEAKY_SHR = 7;
  localparam int MUL_W     = SUM_W + 4;
  localparam int RND_W     = SUM_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Negative inputs are scaled by 13/128 with floor rounding.
  function automatic logic signed [SUM_W-1:0] leaky_relu(input logic signed [SUM_W-1:0] s);
    logic signed [MUL_W-1:0] s_ext;
    logic signed [MUL_W-1:0] mul_k;
    logic signed [MUL_W-1:0] prod;
    logic signed [MUL_W-1:0] scaled;
    s_ext  = MUL_W'(s);
    mul_k  = MUL_W'(LEAKY_MUL);
    prod   = s_ext * mul_k;
    scaled = prod >>> LEAKY_SHR;
    return s[SUM_W-1] ? SUM_W'(scaled) : s;
  endfunction

  // Round-half-up right shift, then clamp to the int8 range.
  function automatic logic signed [OUT_W-1:0] requant(input logic signed [SUM_W-1:0] y,
                                                      input logic [3:0] sh);
    logic signed [RND_W-1:0] y_ext;
    logic signed [RND_W-1:0] rnd;
    logic signed [RND_W-1:0] shifted;
    y_ext   = RND_W'(y);
    rnd     = (sh == 4'd0) ? '0 : (RND_W'(1) << (sh - 4'd1));
    shifted = (y_ext + rnd) >>> sh;
    if (shifted > RND_W'(127)) begin
      return OUT_W'(127);
    end
    if (shifted < RND_W'(-128)) begin
      return OUT_W'(-128);
    end
    return OUT_W'(shifted);
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// First-word-fall-through FIFO with an occupancy count; the head entry is
// visible on pop_data whenever empty is low.
module drain_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] occupancy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt == CNT_W'(DEPTH));
  assign empty     = (cnt == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign pop_data  = mem[rd_ptr];
  assign occupancy = cnt;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // The upstream credit scheme must never let a push reach a full FIFO.
  a_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/module_acc_drain.sv
// Drains a range of the partial-sum buffer through bias, leaky ReLU and
// int8 requantisation, streaming results out over valid/ready.
module module_acc_drain
  import module_acc_drain_pkg::*;
#(
  parameter int DEPTH      = 114 * 114,
  parameter int ADDR_BIT   = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_BIT-1:0]     base_addr,
  input  logic [ADDR_BIT-1:0]     count,
  input  logic signed [ACC_W-1:0] bias,
  input  logic [3:0]              shift,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [ADDR_BIT-1:0]     rd_addr,
  input  logic signed [ACC_W-1:0] rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int CRED_W = CNT_W + 2;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_BIT-1:0]     addr_q;
  logic [ADDR_BIT-1:0]     remaining_q;
  logic signed [ACC_W-1:0] bias_q;
  logic [3:0]              shift_q;
  logic                    v1_q;
  logic                    v2_q;
  logic                    v3_q;
  logic signed [SUM_W-1:0] s_q;
  logic signed [SUM_W-1:0] y_q;
  logic                    done_q;
  logic [CNT_W-1:0]        fifo_occ;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic [OUT_W-1:0]        fifo_head;
  logic [CRED_W-1:0]       in_use;
  logic                    credit_ok;

  // A slot popped this cycle is already free, which keeps one read per cycle
  // flowing when the consumer never stalls.
  assign in_use    = CRED_W'(fifo_occ) + CRED_W'(v1_q) + CRED_W'(v2_q) + CRED_W'(v3_q)
                   - CRED_W'(fifo_pop);
  assign credit_ok = (in_use < CRED_W'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (count == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (rd_en && (remaining_q == ADDR_BIT'(1))) state_nxt = ST_FLUSH;
      ST_FLUSH: if (!v1_q && !v2_q && !v3_q && fifo_empty) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != ST_IDLE);
    rd_en = (state == ST_RUN) && credit_ok;
  end

  assign rd_addr   = addr_q;
  assign done      = done_q;
  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign out_data  = fifo_head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      bias_q      <= '0;
      shift_q     <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      s_q         <= '0;
      y_q         <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state == ST_DONE);
      if ((state == ST_IDLE) && start) begin
        addr_q      <= base_addr;
        remaining_q <= count;
        bias_q      <= bias;
        shift_q     <= shift;
      end else if (rd_en) begin
        addr_q      <= (addr_q == ADDR_BIT'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end
      v1_q <= rd_en;
      v2_q <= v1_q;
      v3_q <= v2_q;
      s_q  <= SUM_W'(rd_data) + SUM_W'(bias_q);
      y_q  <= leaky_relu(s_q);
    end
  end

  drain_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (v3_q),
    .push_data (requant(y_q, shift_q)),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

endmodule
